// File: rtl/mem_if_pkg.sv
// Shared definitions for the processor memory-interface initiator: FSM encodings,
// default memory depth, latency counter width and the data returned on a fault.
package mem_if_pkg;

  localparam int MEM_WORDS_DEFAULT = 1024;
  localparam int CNT_W             = 3;      // holds MEM_LATENCY values 1..7
  localparam logic [31:0] FAULT_DATA = 32'h0;

  typedef enum logic {
    F_IDLE,
    F_WAIT
  } fetch_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_READ,
    D_WRITE
  } data_state_e;

endpackage

// File: rtl/mem_access_controller_if.sv
// Pipeline-side request/response handshakes of the memory access controller.
// master = pipeline, slave = controller.
interface mem_access_controller_if #(
  parameter int ADDR_W = 32
);
  logic              FetchReqValid;
  logic [ADDR_W-1:0] FetchReqAddr;
  logic              FetchReqReady;
  logic              FetchRspValid;
  logic [31:0]       FetchRspInst;
  logic              FetchFault;

  logic              DataReqValid;
  logic              DataReqWrite;
  logic [ADDR_W-1:0] DataReqAddr;
  logic [31:0]       DataReqWdata;
  logic              DataReqReady;
  logic              DataRspValid;
  logic [31:0]       DataRspRdata;
  logic              DataFault;

  modport master (
    output FetchReqValid, FetchReqAddr,
    input  FetchReqReady, FetchRspValid, FetchRspInst, FetchFault,
    output DataReqValid, DataReqWrite, DataReqAddr, DataReqWdata,
    input  DataReqReady, DataRspValid, DataRspRdata, DataFault
  );

  modport slave (
    input  FetchReqValid, FetchReqAddr,
    output FetchReqReady, FetchRspValid, FetchRspInst, FetchFault,
    input  DataReqValid, DataReqWrite, DataReqAddr, DataReqWdata,
    output DataReqReady, DataRspValid, DataRspRdata, DataFault
  );
endinterface

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that stops at zero; zero flags the end of an access wait.
module mem_latency_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_controller.sv
// Initiator side of the split instruction/data memory interface: independent fetch
// and load/store channels, fixed access latency, range faults and store forwarding.
module mem_access_controller
  import mem_if_pkg::*;
#(
  parameter int MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_access_controller_if.slave  pipe,
  output logic [ADDR_W-1:0]       InstAdd,
  output logic [ADDR_W-1:0]       DataAdd,
  output logic [31:0]             MemDataContent,
  output logic                    DataReadEn,
  output logic                    DataWriteEn,
  input  logic [31:0]             MemInstOut,
  input  logic [31:0]             MemDataOut
);

  localparam logic [ADDR_W:0]  WORDS_LIM = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAT       = CNT_W'(MEM_LATENCY);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < WORDS_LIM;
  endfunction

  fetch_state_e      f_state;
  data_state_e       d_state;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic              f_fault, d_fault;
  logic              st_done;
  logic              f_zero, d_zero;

  // Last in-range store; the memory read port does not see a write to an unchanged address.
  logic              ls_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_data;

  logic fetch_accept, data_accept, f_fwd, d_fwd;
  assign fetch_accept = pipe.FetchReqValid && pipe.FetchReqReady;
  assign data_accept  = pipe.DataReqValid && pipe.DataReqReady;
  assign f_fwd        = ls_valid && (ls_addr == f_addr);
  assign d_fwd        = ls_valid && (ls_addr == d_addr);

  mem_latency_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk(clk), .rst_n(rst_n), .load(fetch_accept), .load_val(LAT),
    .en(f_state == F_WAIT), .zero(f_zero)
  );

  mem_latency_counter #(.W(CNT_W)) u_data_cnt (
    .clk(clk), .rst_n(rst_n), .load(data_accept && !pipe.DataReqWrite), .load_val(LAT),
    .en(d_state == D_READ), .zero(d_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state            <= F_IDLE;
      f_addr             <= '0;
      f_fault            <= 1'b0;
      InstAdd            <= '0;
      pipe.FetchReqReady <= 1'b0;
      pipe.FetchRspValid <= 1'b0;
      pipe.FetchRspInst  <= '0;
      pipe.FetchFault    <= 1'b0;
    end else begin
      pipe.FetchRspValid <= 1'b0;
      pipe.FetchFault    <= 1'b0;
      unique case (f_state)
        F_IDLE: begin
          pipe.FetchReqReady <= 1'b1;
          if (fetch_accept) begin
            f_state            <= F_WAIT;
            pipe.FetchReqReady <= 1'b0;
            f_addr             <= pipe.FetchReqAddr;
            f_fault            <= !in_range(pipe.FetchReqAddr);
            if (in_range(pipe.FetchReqAddr)) InstAdd <= pipe.FetchReqAddr;
          end
        end
        F_WAIT: begin
          if (f_zero) begin
            f_state            <= F_IDLE;
            pipe.FetchReqReady <= 1'b1;
            pipe.FetchRspValid <= 1'b1;
            pipe.FetchFault    <= f_fault;
            pipe.FetchRspInst  <= f_fault ? FAULT_DATA : (f_fwd ? ls_data : MemInstOut);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state           <= D_IDLE;
      d_addr            <= '0;
      d_fault           <= 1'b0;
      st_done           <= 1'b0;
      DataAdd           <= '0;
      MemDataContent    <= '0;
      DataReadEn        <= 1'b0;
      DataWriteEn       <= 1'b0;
      ls_valid          <= 1'b0;
      ls_addr           <= '0;
      ls_data           <= '0;
      pipe.DataReqReady <= 1'b0;
      pipe.DataRspValid <= 1'b0;
      pipe.DataRspRdata <= '0;
      pipe.DataFault    <= 1'b0;
    end else begin
      pipe.DataRspValid <= 1'b0;
      pipe.DataFault    <= 1'b0;
      case (d_state)
        D_IDLE: begin
          if (st_done) begin
            // Store completion: ready stays low until the response has gone out.
            st_done           <= 1'b0;
            pipe.DataReqReady <= 1'b1;
            pipe.DataRspValid <= 1'b1;
            pipe.DataFault    <= d_fault;
            pipe.DataRspRdata <= FAULT_DATA;
          end else if (data_accept) begin
            pipe.DataReqReady <= 1'b0;
            d_addr            <= pipe.DataReqAddr;
            d_fault           <= !in_range(pipe.DataReqAddr);
            d_state           <= pipe.DataReqWrite ? D_WRITE : D_READ;
            if (in_range(pipe.DataReqAddr)) begin
              DataAdd <= pipe.DataReqAddr;
              if (pipe.DataReqWrite) begin
                MemDataContent <= pipe.DataReqWdata;
                DataWriteEn    <= 1'b1;
                ls_valid       <= 1'b1;
                ls_addr        <= pipe.DataReqAddr;
                ls_data        <= pipe.DataReqWdata;
              end else begin
                DataReadEn <= 1'b1;
              end
            end
          end else begin
            pipe.DataReqReady <= 1'b1;
          end
        end
        D_READ: begin
          if (d_zero) begin
            d_state           <= D_IDLE;
            DataReadEn        <= 1'b0;
            pipe.DataReqReady <= 1'b1;
            pipe.DataRspValid <= 1'b1;
            pipe.DataFault    <= d_fault;
            pipe.DataRspRdata <= d_fault ? FAULT_DATA : (d_fwd ? ls_data : MemDataOut);
          end
        end
        D_WRITE: begin
          d_state     <= D_IDLE;
          DataWriteEn <= 1'b0;
          st_done     <= 1'b1;
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

endmodule
